// File: rtl/axi_lite_mem_arbiter.sv
// Two-requester AXI4-Lite master arbiter; read and write grants are held until the response handshake.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins), otherwise round-robin.
module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // requester 0
    input  logic              m0_ARVALID,
    input  logic [ADDR_W-1:0] m0_ARADDR,
    output logic              m0_ARREADY,
    output logic              m0_RVALID,
    output logic [DATA_W-1:0] m0_RDATA,
    output logic [1:0]        m0_RRESP,
    input  logic              m0_RREADY,
    input  logic              m0_AWVALID,
    input  logic [ADDR_W-1:0] m0_AWADDR,
    output logic              m0_AWREADY,
    input  logic              m0_WVALID,
    input  logic [DATA_W-1:0] m0_WDATA,
    output logic              m0_WREADY,
    output logic              m0_BVALID,
    output logic [1:0]        m0_BRESP,
    input  logic              m0_BREADY,
    // requester 1
    input  logic              m1_ARVALID,
    input  logic [ADDR_W-1:0] m1_ARADDR,
    output logic              m1_ARREADY,
    output logic              m1_RVALID,
    output logic [DATA_W-1:0] m1_RDATA,
    output logic [1:0]        m1_RRESP,
    input  logic              m1_RREADY,
    input  logic              m1_AWVALID,
    input  logic [ADDR_W-1:0] m1_AWADDR,
    output logic              m1_AWREADY,
    input  logic              m1_WVALID,
    input  logic [DATA_W-1:0] m1_WDATA,
    output logic              m1_WREADY,
    output logic              m1_BVALID,
    output logic [1:0]        m1_BRESP,
    input  logic              m1_BREADY,
    // shared downstream port
    output logic              s_ARVALID,
    output logic [ADDR_W-1:0] s_ARADDR,
    input  logic              s_ARREADY,
    input  logic              s_RVALID,
    input  logic [DATA_W-1:0] s_RDATA,
    input  logic [1:0]        s_RRESP,
    output logic              s_RREADY,
    output logic              s_AWVALID,
    output logic [ADDR_W-1:0] s_AWADDR,
    input  logic              s_AWREADY,
    output logic              s_WVALID,
    output logic [DATA_W-1:0] s_WDATA,
    input  logic              s_WREADY,
    input  logic              s_BVALID,
    input  logic [1:0]        s_BRESP,
    output logic              s_BREADY
);

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Contention goes to the requester that did not finish last.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic last);
        logic gnt;
        if (req0 && req1) begin
            gnt = ~last;
        end else if (req1) begin
            gnt = 1'b1;
        end else begin
            gnt = 1'b0;
        end
        return gnt;
    endfunction

    rd_state_t rd_state_r, rd_state_s;
    wr_state_t wr_state_r, wr_state_s;
    logic      rd_gnt_r, rd_gnt_s, rd_done_s, rd_last_s;
    logic      wr_gnt_r, wr_gnt_s, wr_done_s, wr_last_s;
    logic      aw_done_r, aw_done_s, w_done_r, w_done_s;
    logic      ar_valid_s, r_ready_s, aw_valid_s, w_valid_s, b_ready_s;

`ifdef ARB_FIXED_PRIO_EN
    assign rd_last_s = 1'b1;
    assign wr_last_s = 1'b1;
`else
    logic rd_last_r, wr_last_r;
    assign rd_last_s = rd_last_r;
    assign wr_last_s = wr_last_r;

    // Round-robin history: remember who completed the most recent transaction per channel.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_last_r <= 1'b1;
            wr_last_r <= 1'b1;
        end else begin
            if (rd_done_s) rd_last_r <= rd_gnt_r;
            if (wr_done_s) wr_last_r <= wr_gnt_r;
        end
    end
`endif

    // State, grant and sticky-flag registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_r <= RD_IDLE;
            rd_gnt_r   <= 1'b0;
            wr_state_r <= WR_IDLE;
            wr_gnt_r   <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            rd_state_r <= rd_state_s;
            rd_gnt_r   <= rd_gnt_s;
            wr_state_r <= wr_state_s;
            wr_gnt_r   <= wr_gnt_s;
            aw_done_r  <= aw_done_s;
            w_done_r   <= w_done_s;
        end
    end

    // Read FSM next state and read-channel routing.
    always_comb begin
        rd_state_s = rd_state_r;
        rd_gnt_s   = rd_gnt_r;
        rd_done_s  = 1'b0;
        ar_valid_s = 1'b0;
        r_ready_s  = 1'b0;
        s_ARVALID  = 1'b0;
        s_ARADDR   = ADDR_ZERO;
        s_RREADY   = 1'b0;
        m0_ARREADY = 1'b0;
        m1_ARREADY = 1'b0;
        m0_RVALID  = 1'b0;
        m1_RVALID  = 1'b0;
        m0_RDATA   = DATA_ZERO;
        m1_RDATA   = DATA_ZERO;
        m0_RRESP   = 2'b00;
        m1_RRESP   = 2'b00;
        case (rd_state_r)
            RD_IDLE: begin
                if (m0_ARVALID || m1_ARVALID) begin
                    rd_gnt_s   = arb_pick(m0_ARVALID, m1_ARVALID, rd_last_s);
                    rd_state_s = RD_ADDR;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (rd_gnt_r) begin
                    ar_valid_s = m1_ARVALID;
                    s_ARADDR   = m1_ARADDR;
                    m1_ARREADY = s_ARREADY;
                end else begin
                    ar_valid_s = m0_ARVALID;
                    s_ARADDR   = m0_ARADDR;
                    m0_ARREADY = s_ARREADY;
                end
                s_ARVALID = ar_valid_s;
                if (ar_valid_s && s_ARREADY) begin
                    rd_state_s = RD_DATA;
                end else begin
                    rd_state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rd_gnt_r) begin
                    m1_RVALID = s_RVALID;
                    m1_RDATA  = s_RDATA;
                    m1_RRESP  = s_RRESP;
                    r_ready_s = m1_RREADY;
                end else begin
                    m0_RVALID = s_RVALID;
                    m0_RDATA  = s_RDATA;
                    m0_RRESP  = s_RRESP;
                    r_ready_s = m0_RREADY;
                end
                s_RREADY = r_ready_s;
                if (s_RVALID && r_ready_s) begin
                    rd_done_s  = 1'b1;
                    rd_state_s = RD_IDLE;
                end else begin
                    rd_state_s = RD_DATA;
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
            end
        endcase
    end

    // Write FSM next state and AW/W/B routing; AW and W complete independently.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_gnt_s   = wr_gnt_r;
        wr_done_s  = 1'b0;
        aw_done_s  = aw_done_r;
        w_done_s   = w_done_r;
        aw_valid_s = 1'b0;
        w_valid_s  = 1'b0;
        b_ready_s  = 1'b0;
        s_AWVALID  = 1'b0;
        s_AWADDR   = ADDR_ZERO;
        s_WVALID   = 1'b0;
        s_WDATA    = DATA_ZERO;
        s_BREADY   = 1'b0;
        m0_AWREADY = 1'b0;
        m1_AWREADY = 1'b0;
        m0_WREADY  = 1'b0;
        m1_WREADY  = 1'b0;
        m0_BVALID  = 1'b0;
        m1_BVALID  = 1'b0;
        m0_BRESP   = 2'b00;
        m1_BRESP   = 2'b00;
        case (wr_state_r)
            WR_IDLE: begin
                if (m0_AWVALID || m0_WVALID || m1_AWVALID || m1_WVALID) begin
                    wr_gnt_s   = arb_pick(m0_AWVALID || m0_WVALID, m1_AWVALID || m1_WVALID, wr_last_s);
                    wr_state_s = WR_XFER;
                end else begin
                    wr_state_s = WR_IDLE;
                end
            end
            WR_XFER: begin
                if (wr_gnt_r) begin
                    aw_valid_s = m1_AWVALID && !aw_done_r;
                    w_valid_s  = m1_WVALID && !w_done_r;
                    s_AWADDR   = m1_AWADDR;
                    s_WDATA    = m1_WDATA;
                    m1_AWREADY = s_AWREADY && !aw_done_r;
                    m1_WREADY  = s_WREADY && !w_done_r;
                end else begin
                    aw_valid_s = m0_AWVALID && !aw_done_r;
                    w_valid_s  = m0_WVALID && !w_done_r;
                    s_AWADDR   = m0_AWADDR;
                    s_WDATA    = m0_WDATA;
                    m0_AWREADY = s_AWREADY && !aw_done_r;
                    m0_WREADY  = s_WREADY && !w_done_r;
                end
                s_AWVALID = aw_valid_s;
                s_WVALID  = w_valid_s;
                aw_done_s = aw_done_r || (aw_valid_s && s_AWREADY);
                w_done_s  = w_done_r || (w_valid_s && s_WREADY);
                if (aw_done_s && w_done_s) begin
                    wr_state_s = WR_RESP;
                end else begin
                    wr_state_s = WR_XFER;
                end
            end
            WR_RESP: begin
                if (wr_gnt_r) begin
                    m1_BVALID = s_BVALID;
                    m1_BRESP  = s_BRESP;
                    b_ready_s = m1_BREADY;
                end else begin
                    m0_BVALID = s_BVALID;
                    m0_BRESP  = s_BRESP;
                    b_ready_s = m0_BREADY;
                end
                s_BREADY = b_ready_s;
                if (s_BVALID && b_ready_s) begin
                    wr_done_s  = 1'b1;
                    aw_done_s  = 1'b0;
                    w_done_s   = 1'b0;
                    wr_state_s = WR_IDLE;
                end else begin
                    wr_state_s = WR_RESP;
                end
            end
            default: begin
                wr_state_s = WR_IDLE;
                aw_done_s  = 1'b0;
                w_done_s   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/axi_lite_mem_arbiter.md
# axi_lite_mem_arbiter

Two-requester AXI4-Lite master arbiter. It lets two `core_accelerator` instances share the single external memory AXI4-Lite port in the dual-core accelerator top. Read and write channels are arbitrated independently. Each grant is held from address phase through response handshake; by default the grant alternates round-robin.

## Interface
Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of all R/W channels

Ports (`mN_` is requester N, N ∈ {0,1}; `s_` is the shared downstream port):
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- mN_ARVALID in 1, mN_ARADDR in ADDR_W, mN_ARREADY out 1  requester N read address
- mN_RVALID out 1, mN_RDATA out DATA_W, mN_RRESP out 2, mN_RREADY in 1  requester N read data
- mN_AWVALID in 1, mN_AWADDR in ADDR_W, mN_AWREADY out 1  requester N write address
- mN_WVALID in 1, mN_WDATA in DATA_W, mN_WREADY out 1  requester N write data
- mN_BVALID out 1, mN_BRESP out 2, mN_BREADY in 1  requester N write response
- s_ARVALID out 1, s_ARADDR out ADDR_W, s_ARREADY in 1  shared read address
- s_RVALID in 1, s_RDATA in DATA_W, s_RRESP in 2, s_RREADY out 1  shared read data
- s_AWVALID out 1, s_AWADDR out ADDR_W, s_AWREADY in 1  shared write address
- s_WVALID out 1, s_WDATA out DATA_W, s_WREADY in 1  shared write data
- s_BVALID in 1, s_BRESP in 2, s_BREADY out 1  shared write response

## Operation
- Read FSM, RD_IDLE → RD_ADDR → RD_DATA → RD_IDLE:
  - RD_IDLE: if any mN_ARVALID, register rd_gnt (arbitration below) and go to RD_ADDR.
  - RD_ADDR: s_ARVALID/s_ARADDR = granted requester's AR; granted mN_ARREADY = s_ARREADY. On s_ARVALID&s_ARREADY → RD_DATA.
  - RD_DATA: granted mN_RVALID/RDATA/RRESP = s_R*; s_RREADY = granted mN_RREADY. On R handshake → RD_IDLE, rd_last ← rd_gnt.
- Write FSM, WR_IDLE → WR_XFER → WR_RESP → WR_IDLE:
  - WR_IDLE: grant on any mN_AWVALID or mN_WVALID.
  - WR_XFER: AW and W forwarded independently, with sticky flags aw_done/w_done. Each channel's VALID is masked once its flag is set. When both are done → WR_RESP.
  - WR_RESP: B routed to the granted requester. On B handshake → WR_IDLE, wr_last ← wr_gnt; flags clear.
- Arbitration, per channel:
  - Single requester: that requester wins.
  - Both requesting: the requester ≠ *_last wins.
  - *_last resets to 1, so requester 0 wins the first contention.
- Non-granted requester: all its READY/VALID outputs are 0, data/resp outputs are 0. Shared-port outputs are 0 in IDLE.
- RRESP/BRESP (including SLVERR/DECERR) pass through unchanged; the arbiter never generates a response.
- Read and write FSMs are fully independent. One requester may hold the read grant while the other holds the write grant, or the same requester may hold both.
- Grant is fixed until response handshake. A requester dropping VALID before handshake is a protocol violation; the arbiter does not detect it.

## Timing
- Reset (ARESETn low): FSMs go to IDLE, flags clear, rd_last = wr_last = 1. Every VALID/READY output is 0 and every data/addr/resp output is 0, asynchronously.
- Arbitration latency: 1 cycle. mN_ARVALID seen in RD_IDLE at edge k → s_ARVALID high in cycle k+1. Same for AW/W.
- Downstream → upstream paths (READY, R, B) are combinational through the grant mux; there is no added latency.
- Back-to-back: return to IDLE costs 1 cycle. Minimum read is 3 cycles with zero-wait downstream.
- Reset mid-transaction: the transaction is abandoned and no response is forwarded. The downstream slave shares ARESETn.
- Simultaneous request on the same cycle the other requester's transaction completes: the new grant is decided in the following IDLE cycle using the updated *_last.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: requester 0 always wins contention on both channels. The rd_last/wr_last registers are not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset: ARESETn low mid-read in RD_DATA → all outputs 0 immediately; after release, a new m1 read at 0x100 completes normally.
- Single read: m0 AR 0x0000_0040, slave returns RDATA 0xDEAD_BEEF, RRESP 0 → m0_RDATA = 0xDEAD_BEEF; m1_RVALID stays 0; s_ARVALID rises 1 cycle after m0_ARVALID.
- Contention: m0 and m1 both ARVALID continuously with 4 reads each → grants alternate 0,1,0,1,…; with `ARB_FIXED_PRIO_EN`, all four m0 reads complete before any m1 read.
- Write W-before-AW: m1 WVALID (0x1234_5678) 2 cycles ahead of AWVALID (0x200) → s_W handshakes first, s_AWVALID follows, BRESP 0 is delivered only to m1.
- Concurrency: m0 write and m1 read issued together → both complete with no stalls between channels. Slave RRESP = 2'b10 reaches m1_RRESP unchanged.
